layer_sequencer: RTL and testbench

Controller that runs one fully-connected layer pass over the 10-neuron, 21-bit datapath. On `start` it clears the accumulators, streams `N_INPUTS` weight/input reads with matching accumulate strobes, adds bias, then drives the activation stage's `ready` and waits for its `Ready_AF`. It captures the 210-bit activated vector and holds it behind a valid/ready handshake for the next layer. It sits between the layer memories/MAC array and the downstream layer buffer.

---
 rtl/layer_sequencer.sv | 129 ++++++++++++
 tb/tb_layer_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Layer-pass controller: clears the accumulators, streams N_INPUTS weight/input
// reads, adds bias, then handshakes with the activation stage. The activated
// vector is captured and presented downstream behind a valid/ready pair.
module layer_sequencer #(
    parameter int unsigned N_INPUTS = 64,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned VEC_W    = 210,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              bias_en,
    output logic              af_ready,
    input  logic              af_done,
    input  logic [VEC_W-1:0]  af_out,
    output logic [VEC_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);
    localparam logic [TO_W-1:0]   LAST_TO   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        DRAIN = 3'd3,
        BIAS  = 3'd4,
        ACT   = 3'd5,
        HOLD  = 3'd6
    } state_t;

    state_t          state;
    logic [TO_W-1:0] to_cnt;

    // Pass sequencing; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            to_cnt    <= '0;
            busy      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            acc_clr   <= 1'b0;
            acc_en    <= 1'b0;
            bias_en   <= 1'b0;
            af_ready  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            // Single-cycle strobes default low; accumulate trails the read by the memory latency.
            acc_clr <= 1'b0;
            bias_en <= 1'b0;
            err     <= 1'b0;
            acc_en  <= rd_en;

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLEAR;
                        acc_clr <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    state   <= ACCUM;
                    rd_en   <= 1'b1;
                    rd_addr <= '0;
                end
                ACCUM: begin
                    if (rd_addr == LAST_ADDR) begin
                        state   <= DRAIN;
                        rd_en   <= 1'b0;
                        rd_addr <= '0;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    state   <= BIAS;
                    bias_en <= 1'b1;
                end
                BIAS: begin
                    state    <= ACT;
                    af_ready <= 1'b1;
                    to_cnt   <= '0;
                end
                ACT: begin
                    if (af_done) begin
                        state     <= HOLD;
                        out_data  <= af_out;
                        out_valid <= 1'b1;
                        af_ready  <= 1'b0;
                        to_cnt    <= '0;
                    end else if (to_cnt == LAST_TO) begin
                        state    <= IDLE;
                        err      <= 1'b1;
                        af_ready <= 1'b0;
                        busy     <= 1'b0;
                        to_cnt   <= '0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: per-cycle output expectations are derived from the
// pass timeline (cycle offsets from the start edge) and compared every cycle.
module tb_layer_sequencer;

    localparam int N  = 64;
    localparam int AW = 6;
    localparam int VW = 210;
    localparam int TO = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          acc_clr;
    logic          acc_en;
    logic          bias_en;
    logic          af_ready;
    logic          af_done;
    logic [VW-1:0] af_out;
    logic [VW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          err;
    logic          done_arm;

    int vectors     = 0;
    int miscompares = 0;
    logic [VW-1:0] model_out;

    layer_sequencer #(
        .N_INPUTS(N),
        .ADDR_W  (AW),
        .VEC_W   (VW),
        .TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .acc_clr  (acc_clr),
        .acc_en   (acc_en),
        .bias_en  (bias_en),
        .af_ready (af_ready),
        .af_done  (af_done),
        .af_out   (af_out),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err      (err)
    );

    // Activation stage answers combinationally from ready once armed.
    assign af_done = af_ready & done_arm;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control outputs in cycle c of a pass (cycle 0 = start edge).
    function automatic logic [AW+7:0] expect_vec(input int c, input int d, input int h, input bit tmo);
        logic busy_e, rd_e, clr_e, acc_e, bias_e, afr_e, ov_e, err_e;
        logic [AW-1:0] addr_e;
        int p, idle_c;
        p      = N + 4 + d;
        clr_e  = (c == 1);
        rd_e   = (c >= 2) && (c <= N + 1);
        addr_e = rd_e ? AW'(c - 2) : '0;
        acc_e  = (c >= 3) && (c <= N + 2);
        bias_e = (c == N + 3);
        if (tmo) begin
            afr_e  = (c >= N + 4) && (c <= N + 3 + TO);
            err_e  = (c == N + 4 + TO);
            ov_e   = 1'b0;
            idle_c = N + 4 + TO;
        end else begin
            afr_e  = (c >= N + 4) && (c <= p);
            err_e  = 1'b0;
            ov_e   = (c >= p + 1) && (c <= p + 1 + h);
            idle_c = p + 2 + h;
        end
        busy_e = (c >= 1) && (c < idle_c);
        return {busy_e, rd_e, addr_e, clr_e, acc_e, bias_e, afr_e, ov_e, err_e};
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [223:0] t;
        for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom();
        return t[VW-1:0];
    endfunction

    task automatic check_vec(input string tag, input int c, input logic [AW+7:0] e);
        logic [AW+7:0] o;
        o = {busy, rd_en, rd_addr, acc_clr, acc_en, bias_en, af_ready, out_valid, err};
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s ctrl cyc=%0d observed=%h expected=%h", tag, c, o, e);
        end
    endtask

    task automatic check_data(input string tag, input int c);
        vectors++;
        assert (out_data === model_out) else begin
            miscompares++;
            $error("FAIL %s out_data cyc=%0d observed=%h expected=%h", tag, c, out_data, model_out);
        end
    endtask

    // One full pass: d = extra af_done delay, h = HOLD cycles with out_ready low,
    // tmo = activation never answers, poke = pulse start while busy.
    task automatic run_pass(input int d, input int h, input bit tmo, input bit poke,
                            input logic [VW-1:0] pat, input string tag);
        int p, last;
        p    = N + 4 + d;
        last = tmo ? (N + 4 + TO + 3) : (p + 2 + h + 3);
        af_out = pat;
        @(negedge clk);
        start     = 1'b1;
        done_arm  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= last; c++) begin
            done_arm  = !tmo && (c >= p);
            out_ready = !((c >= p + 1) && (c < p + 1 + h));
            start     = poke && ((c == 10) || (!tmo && h >= 2 && c == p + 2) || (!tmo && c == p + 1 + h));
            if (!tmo && c == p + 1) model_out = pat;
            check_vec(tag, c, expect_vec(c, d, h, tmo));
            check_data(tag, c);
            @(negedge clk);
        end
        start    = 1'b0;
        done_arm = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        done_arm  = 1'b0;
        out_ready = 1'b0;
        af_out    = '0;
        model_out = '0;

        // Reset and idle
        repeat (3) @(negedge clk);
        check_vec("reset", 0, '0);
        check_data("reset", 0);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_vec("idle", c, '0);
            check_data("idle", c);
        end

        // Nominal pass with the A5 pattern
        begin
            logic [215:0] a5;
            a5 = {27{8'hA5}};
            run_pass(0, 0, 1'b0, 1'b0, a5[VW-1:0], "nominal");
        end

        // Backpressure with start pokes during HOLD and at the handshake
        run_pass(0, 10, 1'b0, 1'b1, rand_vec(), "backpressure");

        // Slow activation
        run_pass(5, 0, 1'b0, 1'b0, rand_vec(), "slow_af");

        // Activation timeout keeps the previous vector
        run_pass(0, 0, 1'b1, 1'b1, rand_vec(), "timeout");

        // Mid-pass reset in cycle 30
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 30; c++) begin
            check_vec("pre_rst", c, expect_vec(c, 0, 0, 1'b0));
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        model_out = '0;
        check_vec("mid_rst", 30, '0);
        check_data("mid_rst", 30);
        @(negedge clk);
        rst_n = 1'b1;
        run_pass(0, 0, 1'b0, 1'b0, rand_vec(), "after_rst");

        // Randomized passes
        for (int i = 0; i < 5; i++) begin
            run_pass(int'($urandom_range(0, 6)), int'($urandom_range(0, 5)), 1'b0,
                     1'($urandom_range(0, 1)), rand_vec(), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
